// File: rtl/rom_fetch_unit_if.sv
// Fetch-unit bus: ROM address/data, decode-side stall/redirect,
// and the registered instruction handed to decode.
interface rom_fetch_unit_if #(
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] rom_addr;
    logic [31:0]       rom_instr;
    logic              stall;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic [31:0]       ir;
    logic [31:0]       ir_pc;
    logic              ir_valid;
    logic              fault;

    modport master (
        output rom_addr, ir, ir_pc, ir_valid, fault,
        input  rom_instr, stall, redirect_valid, redirect_pc
    );

    modport slave (
        input  rom_addr, ir, ir_pc, ir_valid, fault,
        output rom_instr, stall, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/rom_fetch_unit.sv
// Instruction fetch front end for a combinational test ROM:
// PC, instruction register, stall/redirect handling, sticky fault.
module rom_fetch_unit #(
    parameter int          ADDR_W   = 5,
    parameter logic [31:0] ROM_BASE = 32'h0000_0000,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic clk,
    input logic rst_n,
    rom_fetch_unit_if.master bus
);

    typedef enum logic [1:0] {
        S_RUN,
        S_STALL,
        S_FAULT
    } state_t;

    state_t      state;
    logic [31:0] pc, pc_d;
    logic [31:0] ir, ir_d;
    logic [31:0] ir_pc, ir_pc_d;
    logic        ir_valid, ir_valid_d;
    logic        fault, fault_d;
    logic        pend_valid, pend_valid_d;
    logic [31:0] pend_pc, pend_pc_d;
    logic [32:0] diff;
    logic        pc_bad;

    // Bit 32 is the borrow (pc below base); bits above the window
    // catch pc past the top; low bits catch misalignment.
    assign diff   = {1'b0, pc} - {1'b0, ROM_BASE};
    assign pc_bad = (|diff[32:ADDR_W+2]) | (|diff[1:0]);

    assign bus.rom_addr = pc_bad ? '0 : diff[ADDR_W+1:2];
    assign bus.ir       = ir;
    assign bus.ir_pc    = ir_pc;
    assign bus.ir_valid = ir_valid;
    assign bus.fault    = fault;

    always_comb begin
        state = S_RUN;
        if (fault)          state = S_FAULT;
        else if (bus.stall) state = S_STALL;
    end

    always_comb begin
        pc_d         = pc;
        ir_d         = ir;
        ir_pc_d      = ir_pc;
        ir_valid_d   = ir_valid;
        fault_d      = fault;
        pend_valid_d = pend_valid;
        pend_pc_d    = pend_pc;
        unique case (state)
            S_RUN: begin
                pend_valid_d = 1'b0;
                if (!pc_bad) begin
                    ir_d       = bus.rom_instr;
                    ir_pc_d    = pc;
                    ir_valid_d = 1'b1;
                    if (bus.redirect_valid) pc_d = bus.redirect_pc;
                    else if (pend_valid)    pc_d = pend_pc;
                    else                    pc_d = pc + 32'd4;
                end else begin
                    ir_d       = '0;
                    ir_valid_d = 1'b0;
                    fault_d    = 1'b1;
                    if (bus.redirect_valid) pc_d = bus.redirect_pc;
                end
            end
            S_STALL: begin
                if (bus.redirect_valid) begin
                    pend_valid_d = 1'b1;
                    pend_pc_d    = bus.redirect_pc;
                end
            end
            S_FAULT: begin
                ir_d       = '0;
                ir_valid_d = 1'b0;
                if (bus.redirect_valid) begin
                    pc_d         = bus.redirect_pc;
                    fault_d      = 1'b0;
                    pend_valid_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc         <= RESET_PC;
            ir         <= '0;
            ir_pc      <= '0;
            ir_valid   <= 1'b0;
            fault      <= 1'b0;
            pend_valid <= 1'b0;
            pend_pc    <= '0;
        end else begin
            pc         <= pc_d;
            ir         <= ir_d;
            ir_pc      <= ir_pc_d;
            ir_valid   <= ir_valid_d;
            fault      <= fault_d;
            pend_valid <= pend_valid_d;
            pend_pc    <= pend_pc_d;
        end
    end

endmodule

// File: tb/tb_rom_fetch_unit.sv
// Directed bench for rom_fetch_unit: free-run, redirects, stalls,
// window/misalignment faults and asynchronous reset.
module tb_rom_fetch_unit;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    rom_fetch_unit_if #(.ADDR_W(5)) bus ();

    rom_fetch_unit #(
        .ADDR_W  (5),
        .ROM_BASE(32'h0000_0000),
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // ROM word k holds 0x3401_0000 + k
    assign bus.rom_instr = 32'h3401_0000 + {27'd0, bus.rom_addr};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk_ir(input string tag, input logic v,
                          input logic [31:0] pc, input logic [31:0] ins);
        chk({tag, "_valid"}, {31'd0, bus.ir_valid}, {31'd0, v});
        chk({tag, "_pc"}, bus.ir_pc, pc);
        chk({tag, "_ir"}, bus.ir, ins);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic rv,
                         input logic [31:0] rpc);
        bus.stall          = s;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 32'h0);
        #2;
        chk_ir("rst", 1'b0, 32'h0, 32'h0);
        chk("rst_fault", {31'd0, bus.fault}, 32'd0);
        chk("rst_addr", {27'd0, bus.rom_addr}, 32'd0);
        #10 rst_n = 1'b1;

        // free run
        step();
        chk_ir("run0", 1'b1, 32'h00, 32'h3401_0000);
        step();
        chk_ir("run1", 1'b1, 32'h04, 32'h3401_0001);

        // stall at pc=0x08 with two redirects; the later one wins
        drive(1'b1, 1'b1, 32'h30);
        step();
        drive(1'b1, 1'b1, 32'h50);
        step();
        drive(1'b1, 1'b0, 32'h0);
        step();
        chk_ir("stall_hold", 1'b1, 32'h04, 32'h3401_0001);
        drive(1'b0, 1'b0, 32'h0);
        step();
        chk_ir("rel_slot", 1'b1, 32'h08, 32'h3401_0002);
        chk("rel_addr", {27'd0, bus.rom_addr}, 32'd20);
        step();
        chk_ir("rel_tgt", 1'b1, 32'h50, 32'h3401_0014);

        // pc=0x54: redirect to 0x1C, then to 0x40 from 0x1C
        drive(1'b0, 1'b1, 32'h1C);
        step();
        chk_ir("rd1", 1'b1, 32'h54, 32'h3401_0015);
        drive(1'b0, 1'b1, 32'h40);
        step();
        chk_ir("rd_slot", 1'b1, 32'h1C, 32'h3401_0007);
        drive(1'b0, 1'b0, 32'h0);
        step();
        chk_ir("rd_tgt", 1'b1, 32'h40, 32'h3401_0010);

        // pending redirect overridden by live redirect on release
        drive(1'b1, 1'b1, 32'h30);
        step();
        chk_ir("pend_hold", 1'b1, 32'h40, 32'h3401_0010);
        drive(1'b0, 1'b1, 32'h60);
        step();
        chk_ir("live_slot", 1'b1, 32'h44, 32'h3401_0011);
        drive(1'b0, 1'b0, 32'h0);
        step();
        chk_ir("live_tgt", 1'b1, 32'h60, 32'h3401_0018);

        // run off the window top
        drive(1'b0, 1'b1, 32'h78);
        step();
        drive(1'b0, 1'b0, 32'h0);
        step();
        chk_ir("top78", 1'b1, 32'h78, 32'h3401_001E);
        step();
        chk_ir("top7c", 1'b1, 32'h7C, 32'h3401_001F);
        chk("top_addr", {27'd0, bus.rom_addr}, 32'd0);
        chk("top_nofault", {31'd0, bus.fault}, 32'd0);
        step();
        chk("top_fault", {31'd0, bus.fault}, 32'd1);
        chk_ir("top_nop", 1'b0, 32'h7C, 32'h0);
        drive(1'b1, 1'b0, 32'h0);
        step();
        chk("top_sticky", {31'd0, bus.fault}, 32'd1);
        chk_ir("top_nop2", 1'b0, 32'h7C, 32'h0);
        drive(1'b1, 1'b1, 32'h00);
        step();
        chk("top_clear", {31'd0, bus.fault}, 32'd0);
        chk_ir("top_clr_ir", 1'b0, 32'h7C, 32'h0);
        drive(1'b0, 1'b0, 32'h0);
        step();
        chk_ir("top_recov", 1'b1, 32'h00, 32'h3401_0000);

        // misaligned redirect, stall ignored during fault
        drive(1'b0, 1'b1, 32'h06);
        step();
        chk_ir("mis_slot", 1'b1, 32'h04, 32'h3401_0001);
        chk("mis_addr", {27'd0, bus.rom_addr}, 32'd0);
        drive(1'b0, 1'b0, 32'h0);
        step();
        chk("mis_fault", {31'd0, bus.fault}, 32'd1);
        chk_ir("mis_nop", 1'b0, 32'h04, 32'h0);
        drive(1'b1, 1'b0, 32'h0);
        step();
        chk("mis_sticky", {31'd0, bus.fault}, 32'd1);
        drive(1'b1, 1'b1, 32'h10);
        step();
        chk("mis_clear", {31'd0, bus.fault}, 32'd0);
        chk("mis_addr2", {27'd0, bus.rom_addr}, 32'd4);

        // async reset mid-stall with a pending redirect
        drive(1'b1, 1'b1, 32'h30);
        step();
        rst_n = 1'b0;
        #1;
        chk_ir("arst", 1'b0, 32'h0, 32'h0);
        chk("arst_addr", {27'd0, bus.rom_addr}, 32'd0);
        drive(1'b0, 1'b0, 32'h0);
        #1 rst_n = 1'b1;
        step();
        chk_ir("arst_run0", 1'b1, 32'h00, 32'h3401_0000);
        step();
        chk_ir("arst_run1", 1'b1, 32'h04, 32'h3401_0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
